// File: rtl/sfp_link_supervisor_pkg.sv
// Shared definitions for the SFP link supervisor: state codes, o_fault bit positions, default timings.
package sfp_link_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_PWRUP   = 3'd1,
        ST_RUN     = 3'd2,
        ST_FAULT   = 3'd3,
        ST_BACKOFF = 3'd4,
        ST_LOCKOUT = 3'd5
    } sup_state_e;

    localparam int FLT_TX   = 0;
    localparam int FLT_PLS  = 1;
    localparam int FLT_LOCK = 2;

    localparam int DEF_PWRUP_CYC    = 40000;
    localparam int DEF_BACKOFF_CYC  = 400000;
    localparam int DEF_MAX_RETRY    = 3;
    localparam int DEF_LOS_FILT_CYC = 400;
    localparam int DEF_MAX_ON_CYC   = 16000;
    localparam int DEF_MIN_OFF_CYC  = 4000;

endpackage

// File: rtl/sfp_link_supervisor_if.sv
// Board-side signal bundle of the SFP link supervisor; slave = supervisor, master = board/bench.
interface sfp_link_supervisor_if;
    logic       i_sfp_tx_flt;
    logic       i_sfp_loss_sig;
    logic       i_pls_req;
    logic       o_sfp_tx_dis_n;
    logic       o_drv_en;
    logic       o_rcv_en_n;
    logic       o_pls;
    logic       o_link_up;
    logic [2:0] o_fault;
    logic [2:0] o_state;

    modport slave (
        input  i_sfp_tx_flt, i_sfp_loss_sig, i_pls_req,
        output o_sfp_tx_dis_n, o_drv_en, o_rcv_en_n, o_pls, o_link_up, o_fault, o_state
    );
    modport master (
        output i_sfp_tx_flt, i_sfp_loss_sig, i_pls_req,
        input  o_sfp_tx_dis_n, o_drv_en, o_rcv_en_n, o_pls, o_link_up, o_fault, o_state
    );
endinterface

// File: rtl/sfp_sup_pls_limiter.sv
// Interrupter pulse limiter: caps continuous on-time and enforces a minimum off-time after any pulse end.
module sfp_sup_pls_limiter #(
    parameter int MAX_ON_CYC  = 16000,
    parameter int MIN_OFF_CYC = 4000
) (
    input  logic i_clk,
    input  logic i_res,
    input  logic i_req,
    input  logic i_en,
    output logic o_pls,
    output logic o_limited
);
    localparam int ON_W  = $clog2(MAX_ON_CYC + 1);
    localparam int OFF_W = $clog2(MIN_OFF_CYC + 1);
    localparam logic [ON_W-1:0]  ON_MAX  = ON_W'(MAX_ON_CYC);
    localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(MIN_OFF_CYC);

    logic             r_pls, r_req_d, r_armed, r_limited;
    logic [ON_W-1:0]  r_on_cnt;
    logic [OFF_W-1:0] r_off_cnt;
    logic             w_hit, w_off_ok, w_rise, w_pls_nxt;

    assign w_hit    = r_pls && (r_on_cnt == ON_MAX);
    assign w_off_ok = (r_off_cnt >= OFF_MAX);
    assign w_rise   = i_req && !r_req_d;
    // A running pulse continues; a new one needs a fresh request and a completed off-time.
    assign w_pls_nxt = i_en && i_req && !w_hit && (r_pls || (r_armed && w_off_ok));

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_pls     <= 1'b0;
            r_req_d   <= 1'b0;
            r_armed   <= 1'b1;
            r_limited <= 1'b0;
            r_on_cnt  <= '0;
            r_off_cnt <= '0;
        end else begin
            r_pls     <= w_pls_nxt;
            r_req_d   <= i_req;
            r_limited <= r_limited | w_hit;
            r_on_cnt  <= w_pls_nxt ? r_on_cnt + 1'b1 : '0;
            if (w_pls_nxt)
                r_off_cnt <= '0;
            else if (r_off_cnt != OFF_MAX)
                r_off_cnt <= r_off_cnt + 1'b1;
            if (!i_req)
                r_armed <= 1'b1;
            else if (w_hit || (w_rise && !w_off_ok))
                r_armed <= 1'b0;
        end
    end

    assign o_pls     = r_pls;
    assign o_limited = r_limited;
endmodule

// File: rtl/sfp_link_supervisor.sv
// SFP/LVDS link sequencer: power-up delay, TX fault retry/lockout, LOS filter and interrupter pulse gate.
// Define SFP_SUP_PLS_LIMIT_EN to add the on-time/off-time pulse limiter.
module sfp_link_supervisor
    import sfp_link_supervisor_pkg::*;
#(
    parameter int PWRUP_CYC    = DEF_PWRUP_CYC,
    parameter int BACKOFF_CYC  = DEF_BACKOFF_CYC,
    parameter int MAX_RETRY    = DEF_MAX_RETRY,
    parameter int LOS_FILT_CYC = DEF_LOS_FILT_CYC
`ifdef SFP_SUP_PLS_LIMIT_EN
    ,
    parameter int MAX_ON_CYC   = DEF_MAX_ON_CYC,
    parameter int MIN_OFF_CYC  = DEF_MIN_OFF_CYC
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_res,
    sfp_link_supervisor_if.slave  bus
);
    localparam int SEQ_MAX = (PWRUP_CYC > BACKOFF_CYC) ? PWRUP_CYC : BACKOFF_CYC;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam int RTY_W   = $clog2(MAX_RETRY + 1);
    localparam int LOS_W   = $clog2(LOS_FILT_CYC + 1);
    localparam logic [SEQ_W-1:0] PWRUP_LAST   = SEQ_W'(PWRUP_CYC - 1);
    localparam logic [SEQ_W-1:0] BACKOFF_LAST = SEQ_W'(BACKOFF_CYC - 1);
    localparam logic [RTY_W-1:0] RTY_MAX      = RTY_W'(MAX_RETRY);
    localparam logic [RTY_W-1:0] RTY_LAST     = RTY_W'(MAX_RETRY - 1);
    localparam logic [LOS_W-1:0] LOS_MAX      = LOS_W'(LOS_FILT_CYC);
    localparam logic [LOS_W-1:0] LOS_LAST     = LOS_W'(LOS_FILT_CYC - 1);

    sup_state_e       r_state, w_state_nxt;
    logic [1:0]       r_flt_sync, r_los_sync, r_req_sync;
    logic [SEQ_W-1:0] r_seq_cnt;
    logic [RTY_W-1:0] r_retry_cnt;
    logic [LOS_W-1:0] r_los_cnt;
    logic             r_link_up, r_tx_dis_n, r_drv_en, r_rcv_en_n, r_tx_flt_seen, r_lock_seen;
    logic             w_flt, w_los, w_req;
    logic             w_tx_on, w_rcv_off, w_in_fault, w_in_lock, w_run;
    logic             w_pls, w_pls_lim;
    logic [2:0]       w_fault;

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_flt_sync <= '0;
            r_los_sync <= '0;
            r_req_sync <= '0;
        end else begin
            r_flt_sync <= {r_flt_sync[0], bus.i_sfp_tx_flt};
            r_los_sync <= {r_los_sync[0], bus.i_sfp_loss_sig};
            r_req_sync <= {r_req_sync[0], bus.i_pls_req};
        end
    end
    assign w_flt = r_flt_sync[1];
    assign w_los = r_los_sync[1];
    assign w_req = r_req_sync[1];

    always_ff @(posedge i_clk) begin
        if (i_res) r_state <= ST_OFF;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OFF:     w_state_nxt = ST_PWRUP;
            // A fault seen at power-up expiry takes priority over entering RUN.
            ST_PWRUP:   if (r_seq_cnt == PWRUP_LAST) w_state_nxt = w_flt ? ST_FAULT : ST_RUN;
            ST_RUN:     if (w_flt) w_state_nxt = ST_FAULT;
            ST_FAULT:   w_state_nxt = (r_retry_cnt >= RTY_LAST) ? ST_LOCKOUT : ST_BACKOFF;
            ST_BACKOFF: if (r_seq_cnt == BACKOFF_LAST) w_state_nxt = ST_PWRUP;
            default:    w_state_nxt = ST_LOCKOUT;
        endcase
    end

    always_comb begin
        w_run      = (r_state == ST_RUN);
        w_tx_on    = w_run;
        w_rcv_off  = (r_state == ST_OFF);
        w_in_fault = (r_state == ST_FAULT);
        w_in_lock  = (r_state == ST_LOCKOUT);
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_seq_cnt   <= '0;
            r_retry_cnt <= '0;
        end else begin
            if ((w_state_nxt == r_state) && (r_state == ST_PWRUP || r_state == ST_BACKOFF))
                r_seq_cnt <= r_seq_cnt + 1'b1;
            else
                r_seq_cnt <= '0;
            if (w_in_fault && r_retry_cnt != RTY_MAX)
                r_retry_cnt <= r_retry_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_res || r_state == ST_OFF) begin
            r_los_cnt <= '0;
            r_link_up <= 1'b0;
        end else if (!w_los) begin
            r_los_cnt <= '0;
            r_link_up <= 1'b1;
        end else if (r_los_cnt != LOS_MAX) begin
            r_los_cnt <= r_los_cnt + 1'b1;
            if (r_los_cnt == LOS_LAST) r_link_up <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_tx_dis_n    <= 1'b0;
            r_drv_en      <= 1'b0;
            r_rcv_en_n    <= 1'b1;
            r_tx_flt_seen <= 1'b0;
            r_lock_seen   <= 1'b0;
        end else begin
            r_tx_dis_n    <= w_tx_on;
            r_drv_en      <= w_tx_on;
            r_rcv_en_n    <= w_rcv_off;
            r_tx_flt_seen <= r_tx_flt_seen | w_in_fault;
            r_lock_seen   <= r_lock_seen | w_in_lock;
        end
    end

`ifdef SFP_SUP_PLS_LIMIT_EN
    sfp_sup_pls_limiter #(
        .MAX_ON_CYC (MAX_ON_CYC),
        .MIN_OFF_CYC(MIN_OFF_CYC)
    ) u_pls_lim (
        .i_clk    (i_clk),
        .i_res    (i_res),
        .i_req    (w_req),
        .i_en     (w_run),
        .o_pls    (w_pls),
        .o_limited(w_pls_lim)
    );
`else
    logic r_pls;
    always_ff @(posedge i_clk) begin
        if (i_res) r_pls <= 1'b0;
        else       r_pls <= w_req && w_run;
    end
    assign w_pls     = r_pls;
    assign w_pls_lim = 1'b0;
`endif

    always_comb begin
        w_fault           = '0;
        w_fault[FLT_TX]   = r_tx_flt_seen;
        w_fault[FLT_PLS]  = w_pls_lim;
        w_fault[FLT_LOCK] = r_lock_seen;
    end

    assign bus.o_sfp_tx_dis_n = r_tx_dis_n;
    assign bus.o_drv_en       = r_drv_en;
    assign bus.o_rcv_en_n     = r_rcv_en_n;
    assign bus.o_pls          = w_pls;
    assign bus.o_link_up      = r_link_up;
    assign bus.o_fault        = w_fault;
    assign bus.o_state        = r_state;
endmodule
